// File: rtl/logic_sweep.sv
// rtl/logic_sweep.sv - programmable N-input boolean function with live output and exhaustive truth-table sweep
module logic_sweep #(
   parameter int N = 5,
   parameter logic [2**N-1:0] TT_INIT = 32'hFF14_1414
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [2**N-1:0]   cfg_tt,
   input  logic [N-1:0]      in_vec,
   output logic              z,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              sweep_valid,
   output logic [N-1:0]      sweep_idx,
   output logic              sweep_z,
   output logic [N:0]        ones_cnt
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [N-1:0] IDX_ONE  = 1;
   localparam logic [N-1:0] IDX_LAST = '1;

   state_t          state;
   logic [2**N-1:0] tt;
   logic [N-1:0]    idx;

   // idx rests at 0 outside SWEEP (wrap on completion, clear on abort), so it drives sweep_idx directly
   assign sweep_valid = busy;
   assign sweep_idx   = idx;
   assign sweep_z     = busy & tt[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tt       <= TT_INIT;
         idx      <= '0;
         z        <= 1'b0;
         ones_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         z <= tt[in_vec];
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (cfg_we)
                  tt <= cfg_tt;
               if (start) begin
                  state    <= SWEEP;
                  busy     <= 1'b1;
                  idx      <= '0;
                  ones_cnt <= '0;
               end
            end
            SWEEP: begin
               // abort wins over completion and discards the current cycle's count
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  ones_cnt <= ones_cnt + {{N{1'b0}}, tt[idx]};
                  idx      <= idx + IDX_ONE;
                  if (idx == IDX_LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_sweep.sv
// tb/tb_logic_sweep.sv - self-checking bench for logic_sweep against a truth-table reference model
module tb_logic_sweep;

   localparam logic [31:0] TT_DEF = 32'hFF14_1414;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we, start, abort;
   logic [31:0] cfg_tt;
   logic [4:0]  in_vec;
   logic        z, busy, done, sweep_valid, sweep_z;
   logic [4:0]  sweep_idx;
   logic [5:0]  ones_cnt;

   logic        cfg_we3, start3, abort3;
   logic [7:0]  cfg_tt3;
   logic [2:0]  in_vec3;
   logic        z3, busy3, done3, valid3, sz3;
   logic [2:0]  idx3;
   logic [3:0]  ones3;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] tt_m;
   logic [5:0]  held;

   always #5 clk = ~clk;

   logic_sweep dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .in_vec(in_vec), .z(z),
      .start(start), .abort(abort), .busy(busy), .done(done), .sweep_valid(sweep_valid),
      .sweep_idx(sweep_idx), .sweep_z(sweep_z), .ones_cnt(ones_cnt)
   );

   logic_sweep #(.N(3), .TT_INIT(8'h00)) dut3 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_tt(cfg_tt3), .in_vec(in_vec3), .z(z3),
      .start(start3), .abort(abort3), .busy(busy3), .done(done3), .sweep_valid(valid3),
      .sweep_idx(idx3), .sweep_z(sz3), .ones_cnt(ones3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int count_below(input logic [31:0] t, input int k);
      int s = 0;
      for (int i = 0; i < k; i++) s += int'(t[i]);
      return s;
   endfunction

   task automatic load_table(input logic [31:0] t);
      cfg_tt = t;
      cfg_we = 1'b1;
      tick;
      cfg_we = 1'b0;
      tt_m   = t;
   endtask

   task automatic do_sweep(input logic [31:0] t, input bit with_cfg);
      if (with_cfg) begin
         cfg_tt = t;
         cfg_we = 1'b1;
         tt_m   = t;
      end
      start = 1'b1;
      tick;
      start  = 1'b0;
      cfg_we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("sweep_busy", busy, 1);
         check("sweep_valid", sweep_valid, 1);
         check("sweep_idx", sweep_idx, i);
         check("sweep_z", sweep_z, tt_m[i]);
         check("sweep_no_done", done, 0);
         tick;
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", sweep_valid, 0);
      check("done_idx", sweep_idx, 0);
      check("ones_final", ones_cnt, $countones(tt_m));
      tick;
      check("done_one_cycle", done, 0);
      check("ones_hold", ones_cnt, $countones(tt_m));
   endtask

   task automatic abort_at(input int k);
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (k) tick;
      check("abort_idx", sweep_idx, k);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_valid", sweep_valid, 0);
      check("abort_ones", ones_cnt, count_below(tt_m, k));
      tick;
      check("abort_no_done", done, 0);
      check("abort_ones_hold", ones_cnt, count_below(tt_m, k));
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; cfg_tt = '0; in_vec = '0;
      cfg_we3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; cfg_tt3 = '0; in_vec3 = '0;
      tt_m = TT_DEF;
      #3;
      check("rst_z", z, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", sweep_valid, 0);
      check("rst_idx", sweep_idx, 0);
      check("rst_ones", ones_cnt, 0);
      #9 rst_n = 1'b1;
      tick;

      // live output over every input vector, default table
      for (int i = 0; i < 32; i++) begin
         in_vec = 5'(i);
         tick;
         check("live_z_default", z, tt_m[i]);
      end

      // random tables with random live vectors
      for (int r = 0; r < 4; r++) begin
         load_table($urandom);
         for (int j = 0; j < 12; j++) begin
            int v;
            v = int'($urandom_range(0, 31));
            in_vec = 5'(v);
            tick;
            check("live_z_rand", z, tt_m[v]);
         end
      end

      load_table(TT_DEF);
      do_sweep(TT_DEF, 1'b0);
      check("default_ones_14", ones_cnt, 14);

      do_sweep(32'h0000_0001, 1'b1);
      do_sweep(32'hFFFF_FFFF, 1'b1);
      do_sweep(32'h0000_0000, 1'b1);
      for (int r = 0; r < 3; r++) do_sweep($urandom, 1'b1);

      // abort in IDLE has no effect
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_ones", ones_cnt, $countones(tt_m));

      load_table(TT_DEF);
      abort_at(10);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("restart_idx", sweep_idx, 0);
      check("restart_ones", ones_cnt, 0);
      check("restart_busy", busy, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      abort_at(31);
      load_table($urandom);
      abort_at(int'($urandom_range(0, 31)));

      // start held high and cfg write mid-sweep
      load_table(TT_DEF);
      start = 1'b1;
      tick;
      for (int i = 0; i < 32; i++) begin
         check("held_idx", sweep_idx, i);
         check("held_z", sweep_z, tt_m[i]);
         cfg_we = (i == 15);
         cfg_tt = 32'h0;
         tick;
      end
      cfg_we = 1'b0;
      check("held_done", done, 1);
      check("held_ones", ones_cnt, 14);
      tick;
      check("held_idle_busy", busy, 0);
      check("held_idle_done", done, 0);
      tick;
      check("held_restart_busy", busy, 1);
      check("held_restart_idx", sweep_idx, 0);
      start = 1'b0;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      do_sweep(TT_DEF, 1'b0);

      // reset mid-sweep restores TT_INIT
      load_table(32'hAAAA_5555);
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (20) tick;
      check("pre_rst_idx", sweep_idx, 20);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", sweep_valid, 0);
      check("mid_rst_idx", sweep_idx, 0);
      check("mid_rst_ones", ones_cnt, 0);
      check("mid_rst_z", z, 0);
      check("mid_rst_done", done, 0);
      #4 rst_n = 1'b1;
      tt_m = TT_DEF;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("post_rst_no_done", done, 0);
         check("post_rst_busy", busy, 0);
      end
      do_sweep(TT_DEF, 1'b0);

      // N=3 instance: cfg write and start together
      cfg_tt3 = 8'hFF;
      cfg_we3 = 1'b1;
      start3  = 1'b1;
      tick;
      cfg_we3 = 1'b0;
      start3  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("n3_busy", busy3, 1);
         check("n3_idx", idx3, i);
         check("n3_z", sz3, 1);
         tick;
      end
      check("n3_done", done3, 1);
      check("n3_ones", ones3, 8);
      tick;
      check("n3_idle", busy3 | done3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
